// File: rtl/fetch_seq.sv
// Fetch sequencer: owns the fetch PC, issues instruction reads on the shared memory
// port and tags each one-cycle-late response with its PC for the IF stage latch.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif

module fetch_seq #(
  parameter logic [`SIZE_ADDR-1:0] P_RESET_PC = '0,
  parameter logic [`SIZE_ADDR-1:0] P_PC_STEP  = `SIZE_ADDR'(1)
) (
  input  logic                  iw_clk,
  input  logic                  iw_rst,
  input  logic                  iw_stall,
  input  logic                  iw_dmem_req,
  input  logic                  iw_branch_taken,
  input  logic [`SIZE_ADDR-1:0] iw_branch_pc,
  input  logic                  iw_halt,
  output logic                  ow_imem_req,
  output logic [`SIZE_ADDR-1:0] ow_imem_addr,
  output logic                  ow_dmem_gnt,
  output logic                  ow_ia_valid,
  output logic [`SIZE_ADDR-1:0] ow_pc,
  output logic                  ow_flush,
  output logic                  ow_halted
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t                  state_q, state_d;
  logic [`SIZE_ADDR-1:0]   r_fetch_pc;
  logic                    r_resp_vld;
  logic [`SIZE_ADDR-1:0]   r_resp_pc;
  logic                    issue;
  logic [`SIZE_ADDR-1:0]   issue_addr;

  // A taken branch is issued in the same cycle it is signalled, when the port is free
  assign issue      = (state_q == S_RUN) & ~iw_halt & ~iw_stall & ~iw_dmem_req & ~iw_rst;
  assign issue_addr = iw_branch_taken ? iw_branch_pc : r_fetch_pc;

  always_ff @(posedge iw_clk) begin
    if (iw_rst) state_q <= S_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_RUN:    if (iw_halt && !iw_branch_taken) state_d = S_HALTED;
      S_HALTED: if (iw_branch_taken)             state_d = S_RUN;
      default:                                   state_d = S_RUN;
    endcase
  end

  always_comb begin
    ow_imem_req  = issue;
    ow_imem_addr = issue ? issue_addr : '0;
    ow_dmem_gnt  = iw_dmem_req & ~iw_rst;
    ow_ia_valid  = r_resp_vld & ~iw_stall & ~iw_branch_taken & ~iw_rst;
    ow_pc        = ow_ia_valid ? r_resp_pc : '0;
    ow_flush     = iw_rst | iw_branch_taken;
    ow_halted    = (state_q == S_HALTED) & ~iw_rst;
  end

  // Fetch PC precedence: reset > branch > stall rewind > issue increment > hold
  always_ff @(posedge iw_clk) begin
    if (iw_rst) begin
      r_fetch_pc <= P_RESET_PC;
      r_resp_vld <= 1'b0;
    end else begin
      r_resp_vld <= issue;
      if (iw_branch_taken)
        r_fetch_pc <= issue ? iw_branch_pc + P_PC_STEP : iw_branch_pc;
      else if (r_resp_vld && iw_stall)
        r_fetch_pc <= r_resp_pc;
      else if (issue)
        r_fetch_pc <= r_fetch_pc + P_PC_STEP;
    end
  end

  // Response PC is data only; it is qualified by r_resp_vld everywhere it is used
  always_ff @(posedge iw_clk) begin
    if (issue) r_resp_pc <= issue_addr;
  end

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: per-cycle port checks from the stimulus process and
// a scoreboard monitor that matches every delivered instruction against its expected cycle/PC.
`ifndef SIZE_ADDR
`define SIZE_ADDR 16
`endif

module tb_fetch_seq;
  localparam int AW = `SIZE_ADDR;

  logic          iw_clk;
  logic          iw_rst;
  logic          iw_stall;
  logic          iw_dmem_req;
  logic          iw_branch_taken;
  logic [AW-1:0] iw_branch_pc;
  logic          iw_halt;
  logic          ow_imem_req;
  logic [AW-1:0] ow_imem_addr;
  logic          ow_dmem_gnt;
  logic          ow_ia_valid;
  logic [AW-1:0] ow_pc;
  logic          ow_flush;
  logic          ow_halted;

  fetch_seq dut (
    .iw_clk          (iw_clk),
    .iw_rst          (iw_rst),
    .iw_stall        (iw_stall),
    .iw_dmem_req     (iw_dmem_req),
    .iw_branch_taken (iw_branch_taken),
    .iw_branch_pc    (iw_branch_pc),
    .iw_halt         (iw_halt),
    .ow_imem_req     (ow_imem_req),
    .ow_imem_addr    (ow_imem_addr),
    .ow_dmem_gnt     (ow_dmem_gnt),
    .ow_ia_valid     (ow_ia_valid),
    .ow_pc           (ow_pc),
    .ow_flush        (ow_flush),
    .ow_halted       (ow_halted)
  );

  typedef struct {
    int cyc;
    int pc;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  int   cycnt    = 0;
  bit   running  = 0;

  initial iw_clk = 1'b0;
  always #5 iw_clk = ~iw_clk;

  always @(posedge iw_clk) cycnt <= cycnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h required=%0h", name, cycnt, act, exp);
    end
  endtask

  // Scoreboard monitor: every delivered instruction must match the head of the queue
  always @(negedge iw_clk) begin
    if (running) begin
      if (ow_ia_valid) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_delivery cycle=%0d actual_pc=%0h required=none", cycnt, ow_pc);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cycnt || mon_e.pc != int'(ow_pc)) begin
            failures++;
            $display("FAIL delivery cycle=%0d actual_pc=%0h required_pc=%0h required_cycle=%0d",
                     cycnt, ow_pc, mon_e.pc, mon_e.cyc);
          end
        end
      end else if (q.size() > 0 && q[0].cyc == cycnt) begin
        checks++;
        failures++;
        $display("FAIL missing_delivery cycle=%0d actual_valid=0 required_pc=%0h", cycnt, q[0].pc);
        void'(q.pop_front());
      end
    end
  end

  // One clock: drive inputs, queue the expected delivery, check the per-cycle controls
  task automatic cyc(input int rst_i, input int stall_i, input int dmem_i, input int br_i,
                     input int bpc_i, input int halt_i, input int e_req, input int e_addr,
                     input int e_flush, input int e_gnt, input int e_halted,
                     input int e_v, input int e_pc);
    exp_t e;
    @(posedge iw_clk);
    #1;
    iw_rst          = rst_i[0];
    iw_stall        = stall_i[0];
    iw_dmem_req     = dmem_i[0];
    iw_branch_taken = br_i[0];
    iw_branch_pc    = bpc_i[AW-1:0];
    iw_halt         = halt_i[0];
    if (e_v != 0) begin
      e.cyc = cycnt;
      e.pc  = e_pc;
      q.push_back(e);
    end
    @(negedge iw_clk);
    chk("imem_req",  int'(ow_imem_req),  e_req);
    chk("imem_addr", int'(ow_imem_addr), e_addr);
    chk("flush",     int'(ow_flush),     e_flush);
    chk("dmem_gnt",  int'(ow_dmem_gnt),  e_gnt);
    chk("halted",    int'(ow_halted),    e_halted);
  endtask

  initial begin
    iw_rst          = 1'b1;
    iw_stall        = 1'b0;
    iw_dmem_req     = 1'b0;
    iw_branch_taken = 1'b0;
    iw_branch_pc    = '0;
    iw_halt         = 1'b0;
    running         = 1'b1;
    //  rst st dm br bpc     hl | req addr    fl gnt hlt v  pc
    cyc(1, 0, 0, 0, 0,      0,   0, 0,       1, 0,  0,  0, 0);
    cyc(1, 0, 1, 0, 0,      0,   0, 0,       1, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 0,       0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 1,       0, 0,  0,  1, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 2,       0, 0,  0,  1, 1);
    cyc(0, 0, 0, 0, 0,      0,   1, 3,       0, 0,  0,  1, 2);
    cyc(0, 0, 0, 0, 0,      0,   1, 4,       0, 0,  0,  1, 3);
    cyc(0, 0, 0, 0, 0,      0,   1, 5,       0, 0,  0,  1, 4);
    // stall two cycles with pc 5 in flight: dropped, then refetched
    cyc(0, 1, 0, 0, 0,      0,   0, 0,       0, 0,  0,  0, 0);
    cyc(0, 1, 0, 0, 0,      0,   0, 0,       0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 5,       0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 6,       0, 0,  0,  1, 5);
    cyc(0, 0, 0, 0, 0,      0,   1, 7,       0, 0,  0,  1, 6);
    // branch to 0x40 with pc 7 in flight
    cyc(0, 0, 0, 1, 'h40,   0,   1, 'h40,    1, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h41,    0, 0,  0,  1, 'h40);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h42,    0, 0,  0,  1, 'h41);
    // data-side steal: 0x42 still delivered, 0x43 issued the cycle after
    cyc(0, 0, 1, 0, 0,      0,   0, 0,       0, 1,  0,  1, 'h42);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h43,    0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h44,    0, 0,  0,  1, 'h43);
    // halt: in-flight 0x44 delivered, then HALTED persists after halt drops
    cyc(0, 0, 0, 0, 0,      1,   0, 0,       0, 0,  0,  1, 'h44);
    cyc(0, 0, 0, 0, 0,      1,   0, 0,       0, 0,  1,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   0, 0,       0, 0,  1,  0, 0);
    cyc(0, 0, 0, 1, 'h100,  0,   0, 0,       1, 0,  1,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h100,   0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 'h101,   0, 0,  0,  1, 'h100);
    // branch during a stall beats the rewind; then wrap from all-ones
    cyc(0, 1, 0, 1, 'hFFFF, 0,   0, 0,       1, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 'hFFFF,  0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 0,       0, 0,  0,  1, 'hFFFF);
    cyc(0, 0, 0, 0, 0,      0,   1, 1,       0, 0,  0,  1, 0);
    // reset mid-stream discards the in-flight pc 1
    cyc(1, 0, 0, 0, 0,      0,   0, 0,       1, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 0,       0, 0,  0,  0, 0);
    cyc(0, 0, 0, 0, 0,      0,   1, 1,       0, 0,  0,  1, 0);
    cyc(0, 0, 0, 0, 0,      1,   0, 0,       0, 0,  0,  1, 1);
    cyc(0, 0, 0, 0, 0,      1,   0, 0,       0, 0,  1,  0, 0);
    repeat (2) @(negedge iw_clk);
    running = 1'b0;
    chk("scoreboard_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
